// File: rtl/pal_pkg.sv
// Shared types and configuration bit-map helpers for the registered PAL.
// The bench uses the same helpers to build its configuration vectors.
package pal_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  localparam int DEF_INPUTS  = 4;
  localparam int DEF_TERMS   = 4;
  localparam int DEF_OUTPUTS = 4;

  function automatic int num_lits(input int ni, input int no);
    return 2 * (ni + no);
  endfunction

  function automatic int lit_idx(input int sig, input bit neg);
    return 2 * sig + int'(neg);
  endfunction

  function automatic int and_bit(input int t, input int l, input int ni, input int no);
    return t * num_lits(ni, no) + l;
  endfunction

  function automatic int or_off(input int ni, input int nt, input int no);
    return nt * num_lits(ni, no);
  endfunction

  function automatic int mc_off(input int ni, input int nt, input int no);
    return or_off(ni, nt, no) + no * nt;
  endfunction

  function automatic int cfg_bits(input int ni, input int nt, input int no);
    return mc_off(ni, nt, no) + 2 * no;
  endfunction

  localparam int CFG_BITS = cfg_bits(DEF_INPUTS, DEF_TERMS, DEF_OUTPUTS);

endpackage

// File: rtl/pal_macrocell.sv
// One output macrocell: feedback register plus registered/combinational
// select with optional inversion.
module pal_macrocell
  import pal_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic sum,
  input  logic reg_en,
  input  logic inv,
  input  logic active,
  input  logic out_en,
  output logic q,
  output logic out
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (active) begin
      q <= sum;
    end
  end

  // out_en stays low until the first configuration has committed
  assign out = out_en & ((reg_en ? q : sum) ^ inv);

endmodule

// File: rtl/registered_pal.sv
// Registered PAL: serially loaded shadow config, atomic commit, AND/OR planes
// with macrocell feedback into the AND plane.
//   state | meaning
//   IDLE  | after reset, nothing configured, outputs forced low
//   LOAD  | shifting bits into shadow, active config keeps running
//   RUN   | configured array active, waiting for a reload
module registered_pal
  import pal_pkg::*;
#(
  parameter int NUM_INPUTS  = DEF_INPUTS,
  parameter int NUM_TERMS   = DEF_TERMS,
  parameter int NUM_OUTPUTS = DEF_OUTPUTS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_INPUTS-1:0]  pal_in,
  input  logic                   cfg_start,
  input  logic                   cfg_valid,
  input  logic                   cfg_data,
  output logic                   cfg_busy,
  output logic                   cfg_done,
  output logic                   configured,
  output logic [NUM_OUTPUTS-1:0] pal_out
);

  localparam int S      = NUM_INPUTS + NUM_OUTPUTS;
  localparam int L      = num_lits(NUM_INPUTS, NUM_OUTPUTS);
  localparam int OR_OFF = or_off(NUM_INPUTS, NUM_TERMS, NUM_OUTPUTS);
  localparam int MC_OFF = mc_off(NUM_INPUTS, NUM_TERMS, NUM_OUTPUTS);
  localparam int N_CFG  = cfg_bits(NUM_INPUTS, NUM_TERMS, NUM_OUTPUTS);
  localparam int CW     = $clog2(N_CFG + 1);

  state_t            state, state_nxt;
  logic [CW-1:0]     count, count_nxt;
  logic [N_CFG-1:0]  shadow, shadow_nxt;
  logic [N_CFG-1:0]  active_cfg;
  logic              commit;

  logic [NUM_OUTPUTS-1:0] q;
  logic [S-1:0]           sig;
  logic [L-1:0]           lit;
  logic [NUM_TERMS-1:0]   term;
  logic [NUM_OUTPUTS-1:0] sum;
  logic                   arr_active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      shadow     <= '0;
      active_cfg <= '0;
      configured <= 1'b0;
      cfg_done   <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      shadow   <= shadow_nxt;
      cfg_done <= commit;
      if (commit) begin
        active_cfg <= shadow_nxt;
        configured <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    shadow_nxt = shadow;
    commit     = 1'b0;
    case (state)
      IDLE, RUN: begin
        if (cfg_start) begin
          state_nxt  = LOAD;
          count_nxt  = '0;
          shadow_nxt = '0;
        end
      end
      LOAD: begin
        // a restart discards the partial load; a bit arriving with it is index 0
        if (cfg_start) begin
          count_nxt  = '0;
          shadow_nxt = '0;
          if (cfg_valid) begin
            shadow_nxt[0] = cfg_data;
            count_nxt     = CW'(1);
          end
        end else if (cfg_valid) begin
          shadow_nxt[count] = cfg_data;
          if (count == CW'(N_CFG - 1)) begin
            state_nxt = RUN;
            count_nxt = '0;
            commit    = 1'b1;
          end else begin
            count_nxt = count + CW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cfg_busy   = (state == LOAD);
  assign arr_active = (state != IDLE);
  assign sig        = {q, pal_in};

  for (genvar s = 0; s < S; s++) begin : g_lit
    assign lit[2*s]   = sig[s];
    assign lit[2*s+1] = ~sig[s];
  end

  // an empty term must read 0, not the vacuous AND of nothing
  for (genvar t = 0; t < NUM_TERMS; t++) begin : g_term
    logic [L-1:0] conn;
    assign conn    = active_cfg[t*L +: L];
    assign term[t] = (|conn) & (&(~conn | lit));
  end

  for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_out
    logic [NUM_TERMS-1:0] conn;
    assign conn   = active_cfg[OR_OFF + o*NUM_TERMS +: NUM_TERMS];
    assign sum[o] = |(conn & term);

    pal_macrocell u_mc (
      .clk    (clk),
      .rst_n  (rst_n),
      .sum    (sum[o]),
      .reg_en (active_cfg[MC_OFF + 2*o]),
      .inv    (active_cfg[MC_OFF + 2*o + 1]),
      .active (arr_active),
      .out_en (configured),
      .q      (q[o]),
      .out    (pal_out[o])
    );
  end

endmodule

// File: tb/tb_registered_pal.sv
// Directed bench for registered_pal: configuration loads, combinational and
// registered paths, restart, gapped load, async reset and empty terms.
module tb_registered_pal;
  import pal_pkg::*;

  localparam int NI  = DEF_INPUTS;
  localparam int NT  = DEF_TERMS;
  localparam int NO  = DEF_OUTPUTS;
  localparam int NB  = cfg_bits(NI, NT, NO);
  localparam int OR0 = or_off(NI, NT, NO);
  localparam int MC0 = mc_off(NI, NT, NO);

  typedef logic [NB-1:0] cfg_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NI-1:0] pal_in;
  logic          cfg_start, cfg_valid, cfg_data;
  logic          cfg_busy, cfg_done, configured;
  logic [NO-1:0] pal_out;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  cfg_t cfg_comb, cfg_tog, cfg_tog_inv, cfg_e0, cfg_e1, cfg_junk;
  logic exp_b;
  logic [3:0] vv;

  registered_pal #(.NUM_INPUTS(NI), .NUM_TERMS(NT), .NUM_OUTPUTS(NO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pal_in     (pal_in),
    .cfg_start  (cfg_start),
    .cfg_valid  (cfg_valid),
    .cfg_data   (cfg_data),
    .cfg_busy   (cfg_busy),
    .cfg_done   (cfg_done),
    .configured (configured),
    .pal_out    (pal_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cfg_done === 1'b1) done_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    cfg_valid = 1'b0;
    step();
    cfg_start = 1'b0;
    check("busy_rise", 32'(cfg_busy), 32'd1);
  endtask

  task automatic send_bits(input cfg_t cfg, input int lo, input int hi,
                           input bit gapped, input bit restart);
    for (int i = lo; i <= hi; i++) begin
      cfg_start = restart && (i == lo);
      cfg_valid = 1'b1;
      cfg_data  = cfg[i];
      step();
      cfg_start = 1'b0;
      cfg_valid = 1'b0;
      if (i == NB - 1) begin
        check("done_on_commit", 32'(cfg_done), 32'd1);
        check("busy_fall", 32'(cfg_busy), 32'd0);
        check("configured_set", 32'(configured), 32'd1);
      end else begin
        check("done_quiet", 32'(cfg_done), 32'd0);
        check("busy_load", 32'(cfg_busy), 32'd1);
        if (gapped) begin
          cfg_data = ~cfg[i];
          step();
          check("done_gap", 32'(cfg_done), 32'd0);
        end
      end
    end
  endtask

  initial begin
    cfg_comb = '0;
    cfg_comb[and_bit(0, lit_idx(0, 1'b0), NI, NO)] = 1'b1;
    cfg_comb[and_bit(0, lit_idx(1, 1'b0), NI, NO)] = 1'b1;
    cfg_comb[and_bit(1, lit_idx(2, 1'b1), NI, NO)] = 1'b1;
    cfg_comb[OR0 + 0*NT + 0] = 1'b1;
    cfg_comb[OR0 + 1*NT + 1] = 1'b1;

    cfg_tog = '0;
    cfg_tog[and_bit(0, lit_idx(NI + 0, 1'b1), NI, NO)] = 1'b1;
    cfg_tog[OR0 + 0*NT + 0] = 1'b1;
    cfg_tog[MC0 + 0] = 1'b1;
    cfg_tog_inv = cfg_tog;
    cfg_tog_inv[MC0 + 1] = 1'b1;

    cfg_e0 = '0;
    cfg_e0[and_bit(0, lit_idx(0, 1'b0), NI, NO)] = 1'b1;
    cfg_e0[OR0 + 3*NT + 0] = 1'b1;
    cfg_e0[OR0 + 2*NT + 2] = 1'b1;
    cfg_e1 = cfg_e0;
    cfg_e1[MC0 + 2*2 + 1] = 1'b1;

    cfg_junk = '1;

    rst_n = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = 1'b0; pal_in = 4'hF;
    #3;
    check("reset_out", 32'(pal_out), 32'd0);
    check("reset_configured", 32'(configured), 32'd0);
    check("reset_busy", 32'(cfg_busy), 32'd0);
    check("reset_done", 32'(cfg_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cfg_valid = 1'b1; cfg_data = 1'b1;
    repeat (10) begin
      step();
      check("idle_out", 32'(pal_out), 32'd0);
      check("idle_busy", 32'(cfg_busy), 32'd0);
      check("idle_configured", 32'(configured), 32'd0);
    end
    cfg_valid = 1'b0; cfg_data = 1'b0; pal_in = 4'h0;

    // combinational load
    pulse_start();
    send_bits(cfg_comb, 0, NB - 1, 1'b0, 1'b0);
    step();
    check("done_one_cycle", 32'(cfg_done), 32'd0);
    pal_in = 4'b0011; #1 check("comb_0011", 32'(pal_out), 32'h3);
    pal_in = 4'b0100; #1 check("comb_0100", 32'(pal_out), 32'h0);
    pal_in = 4'b0111; #1 check("comb_0111", 32'(pal_out), 32'h1);

    // registered toggle through feedback
    pal_in = 4'h0;
    step();
    pulse_start();
    send_bits(cfg_tog, 0, NB - 1, 1'b0, 1'b0);
    exp_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("toggle", 32'(pal_out), 32'({3'b000, exp_b}));
      exp_b = ~exp_b;
      step();
    end

    // gapped load
    pal_in = 4'b0011;
    pulse_start();
    send_bits(cfg_comb, 0, NB - 1, 1'b1, 1'b0);
    #1 check("gapped_out", 32'(pal_out), 32'h3);

    // restart at bit 40, old config stays live meanwhile
    step();
    pulse_start();
    send_bits(cfg_junk, 0, 39, 1'b0, 1'b0);
    check("midload_old_cfg", 32'(pal_out), 32'h3);
    check("midload_configured", 32'(configured), 32'd1);
    send_bits(cfg_e0, 0, NB - 1, 1'b0, 1'b1);
    for (int v = 0; v < 16; v++) begin
      vv = 4'(v);
      pal_in = vv;
      #1 check("empty_term", 32'(pal_out), 32'({vv[0], 3'b000}));
    end

    step();
    pulse_start();
    send_bits(cfg_e1, 0, NB - 1, 1'b0, 1'b0);
    for (int v = 0; v < 16; v++) begin
      vv = 4'(v);
      pal_in = vv;
      #1 check("empty_term_inv", 32'(pal_out), 32'({vv[0], 3'b100}));
    end

    // async reset in the middle of a load
    pal_in = 4'b0101;
    step();
    check("pre_reset_out", 32'(pal_out), 32'hC);
    pulse_start();
    send_bits(cfg_comb, 0, 49, 1'b0, 1'b0);
    check("midload_out", 32'(pal_out), 32'hC);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_out", 32'(pal_out), 32'd0);
    check("async_rst_configured", 32'(configured), 32'd0);
    check("async_rst_busy", 32'(cfg_busy), 32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) begin
      step();
      check("post_rst_busy", 32'(cfg_busy), 32'd0);
      check("post_rst_out", 32'(pal_out), 32'd0);
      check("post_rst_configured", 32'(configured), 32'd0);
    end

    // inverted toggle, loaded from IDLE
    pulse_start();
    send_bits(cfg_tog_inv, 0, NB - 1, 1'b0, 1'b0);
    exp_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("toggle_inv", 32'(pal_out), 32'({3'b000, exp_b}));
      exp_b = ~exp_b;
      step();
    end

    step();
    check("done_pulse_count", 32'(done_cnt), 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/registered_pal.md
# registered_pal

Field-programmable registered PAL for the PAL board build. It extends the fixed combinational AND/OR arrays with three additions: a serially loaded configuration, per-output macrocells that choose a registered or combinational path with optional inversion, and registered feedback into the AND plane. A new configuration loads into a shadow store while the old one keeps running, then commits atomically. It sits between the debounced button inputs and the LED outputs of the top-level wrapper.

## Interface
- NUM_INPUTS, default 4: external input signals.
- NUM_TERMS, default 4: product terms in the AND plane.
- NUM_OUTPUTS, default 4: macrocells and outputs; every macrocell register feeds back into the AND plane.
- clk  in  1  sole clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pal_in  in  NUM_INPUTS  logic inputs.
- cfg_start  in  1  single-cycle pulse that begins a configuration load.
- cfg_valid  in  1  qualifies cfg_data.
- cfg_data  in  1  serial configuration bit.
- cfg_busy  out  1  high while in LOAD.
- cfg_done  out  1  one-cycle pulse on commit.
- configured  out  1  high once any configuration has committed.
- pal_out  out  NUM_OUTPUTS  macrocell outputs.

## Operation
- Derived constants:
  - S = NUM_INPUTS+NUM_OUTPUTS signals; signal s<NUM_INPUTS is pal_in[s], otherwise q[s-NUM_INPUTS].
  - L = 2S literals; literal 2s is signal s, literal 2s+1 is ~signal s.
  - AND_BITS = NUM_TERMS·L, OR_BITS = NUM_OUTPUTS·NUM_TERMS, MC_BITS = 2·NUM_OUTPUTS.
  - CFG_BITS = sum of the three.
- Config bit map, with index k set by the k-th accepted bit:
  - AND plane: bit t·L+l connects literal l to term t.
  - OR plane: bit AND_BITS+o·NUM_TERMS+t connects term t to output o.
  - Macrocells: bit AND_BITS+OR_BITS+2o is reg_en[o]; the next bit is inv[o].
- Term t is the AND of its connected literals. A term with no connected literals evaluates to 0.
- Sum[o] is the OR of its connected terms. With no terms connected, sum[o] = 0.
- Macrocell:
  - q[o] <= sum[o] when the array is active.
  - pal_out[o] = (reg_en[o] ? q[o] : sum[o]) ^ inv[o].
- Every macrocell clocks its register; for combinational cells it is simply unused except through feedback.
- State machine:
  - IDLE (reset state): active config is all zero, q held 0, pal_out forced 0. cfg_start → LOAD.
  - LOAD: each cycle with cfg_valid high writes cfg_data into shadow[count] and increments count. The array keeps running on the active config, except that pal_out stays 0 if entered from IDLE. Accepting the bit at count = CFG_BITS-1 → RUN.
  - RUN: array active. cfg_start → LOAD.
- Commit, on the edge after the last accepted bit:
  - active config ← shadow; count ← 0.
  - cfg_done = 1 for one cycle; configured ← 1.
- cfg_start in LOAD restarts the load: count ← 0 and shadow contents are discarded. If cfg_valid is high in the same cycle, that bit is stored as index 0.
- cfg_valid outside LOAD is ignored.
- Reset (asynchronous, any time including mid-load): state IDLE, count 0, shadow and active config 0, q 0, cfg_busy 0, cfg_done 0, configured 0, pal_out 0.

## Timing
- pal_in to pal_out on a combinational cell: 0 cycles (combinational).
- Registered cell: pal_out reflects pal_in sampled at the preceding edge, so 1 cycle of latency.
- Feedback: q is sampled at an edge, and the next state follows from it, 1 cycle later.
- cfg_busy rises the cycle after cfg_start and falls on the cycle cfg_done is high.
- The first cycle after commit evaluates with the new config. q is not cleared at commit.
- Minimum load time: CFG_BITS cycles with cfg_valid held high. Gaps in cfg_valid are allowed.

## Structure
- Package pal_pkg contains:
  - state enum {IDLE, LOAD, RUN};
  - CFG_BITS and the offset computation functions (literal index, OR offset, MC offset), shared with the bench's config generator.
- Sub-module pal_macrocell: sum, reg_en, inv, active/enable inputs; q, out outputs. Instantiated NUM_OUTPUTS times.
- Count register width is $clog2(CFG_BITS+1).

## Test plan
All scenarios use the defaults, so S=8, L=16, CFG_BITS=88.
- Reset then idle: pal_in=4'hF for 10 cycles → pal_out=0, configured=0, cfg_busy=0.
- Combinational load:
  - Config: term0 = in0·in1 → out0; term1 = ~in2 → out1; reg_en=0; inv=0.
  - Drive in=4'b0011 → pal_out[1:0]=2'b11.
  - Drive in=4'b0100 → pal_out[1:0]=2'b00.
  - cfg_done pulses once, exactly 88 valid cycles after start.
- Registered toggle:
  - Config: out0 registered, term0 = ~q0 → out0.
  - pal_out[0] alternates 0,1,0,1 each cycle after commit.
  - Setting inv0=1 inverts the sequence.
- Gapped and restarted load:
  - cfg_valid de-asserted every other cycle: commit still occurs after 88 accepted bits.
  - cfg_start at bit 40: old config stays active on pal_out; the new config commits only after a further 88 bits.
- Reset mid-load: assert rst_n=0 at bit 50 of a load that follows a committed config → all outputs 0 and configured=0 immediately (asynchronously); after release the block is in IDLE.
- Empty term: a term with no literals connected to out2 → pal_out[2]=0 for all 16 input values; with inv2=1 it is 1.
